// File: rtl/aes_sbox_sub_bytes_if.sv
// Valid/ready bus for the SubBytes engine: a state word plus its mode goes in,
// and the substituted word comes out.
interface aes_sbox_sub_bytes_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_inv;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output in_valid, in_data, in_inv, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_inv, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_sbox_sub_bytes.sv
// AES SubBytes engine: LANES registered S-box lookups per cycle over a latched
// DATA_W-bit word. Forward or inverse table is chosen once per word.
module aes_sbox_sub_bytes #(
  parameter int DATA_W   = 128,
  parameter int LANES    = 4,
  parameter int SBOX_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  aes_sbox_sub_bytes_if.slave bus,
  output logic                busy
);
  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
    $fatal(1, "aes_sbox_sub_bytes: DATA_W must be a positive multiple of 8");
  end
  if (LANES < 1 || NBYTES % LANES != 0) begin : g_bad_lanes
    $fatal(1, "aes_sbox_sub_bytes: LANES must divide DATA_W/8");
  end
  if (SBOX_LAT != 1 && SBOX_LAT != 2) begin : g_bad_lat
    $fatal(1, "aes_sbox_sub_bytes: SBOX_LAT must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  localparam logic [0:255][7:0] FWD_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic inv, input logic [7:0] b);
    return inv ? INV_TAB[b] : FWD_TAB[b];
  endfunction

  state_t                state_q, state_d;
  logic [NBYTES-1:0][7:0] data_q;
  logic [NBYTES-1:0][7:0] result_q;
  logic                  inv_q;
  logic [IDX_W-1:0]      idx_q;
  logic [SBOX_LAT-1:0]   pipe_vld;
  logic [SBOX_LAT-1:0]   pipe_last;
  logic [LANES-1:0][7:0] pipe_data [SBOX_LAT];
  logic [IDX_W-1:0]      pipe_idx  [SBOX_LAT];
  logic [LANES-1:0][7:0] lane_out;

  logic accept, issue, last_grp, last_written;

  assign accept       = (state_q == IDLE) && bus.in_valid;
  assign issue        = (state_q == ISSUE);
  assign last_grp     = (idx_q == IDX_W'(NBYTES - LANES));
  assign last_written = pipe_vld[SBOX_LAT-1] && pipe_last[SBOX_LAT-1];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane_out = '0;
    for (int l = 0; l < LANES; l++)
      lane_out[l] = sbox(inv_q, data_q[idx_q + IDX_W'(l)]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = ISSUE;
      ISSUE:   if (last_grp)     state_d = DRAIN;
      DRAIN:   if (last_written) state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      inv_q     <= 1'b0;
      idx_q     <= '0;
      result_q  <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= bus.in_data;
        inv_q  <= bus.in_inv;
        idx_q  <= '0;
      end else if (issue) begin
        idx_q <= idx_q + IDX_W'(LANES);
      end
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && last_grp;
      for (int s = 1; s < SBOX_LAT; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_last[s] <= pipe_last[s-1];
      end
      // Each lane result lands back in the byte slot it was read from.
      if (pipe_vld[SBOX_LAT-1])
        for (int l = 0; l < LANES; l++)
          result_q[pipe_idx[SBOX_LAT-1] + IDX_W'(l)] <= pipe_data[SBOX_LAT-1][l];
    end
  end

  // NOTE: lookup data and slot pipes carry no reset; the reset valid bits already gate their use.
  always_ff @(posedge clk) begin
    pipe_data[0] <= lane_out;
    pipe_idx[0]  <= idx_q;
    for (int s = 1; s < SBOX_LAT; s++) begin
      pipe_data[s] <= pipe_data[s-1];
      pipe_idx[s]  <= pipe_idx[s-1];
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = result_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_aes_sbox_sub_bytes.sv
// Self-checking bench for aes_sbox_sub_bytes: a default instance for the scenario
// tests and four parameter variants driven in lockstep for the sweep.
module tb_aes_sbox_sub_bytes;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  aes_sbox_sub_bytes_if #(.DATA_W(128)) b0 ();
  logic busy0;
  aes_sbox_sub_bytes dut0 (.clk(clk), .rst(rst), .bus(b0.slave), .busy(busy0));

  aes_sbox_sub_bytes_if #(.DATA_W(128)) s1 ();
  aes_sbox_sub_bytes_if #(.DATA_W(128)) s2 ();
  aes_sbox_sub_bytes_if #(.DATA_W(128)) s3 ();
  aes_sbox_sub_bytes_if #(.DATA_W(32))  s4 ();
  logic [3:0] sw_busy;
  aes_sbox_sub_bytes #(.DATA_W(128), .LANES(1),  .SBOX_LAT(2)) dut1 (.clk(clk), .rst(rst), .bus(s1.slave), .busy(sw_busy[0]));
  aes_sbox_sub_bytes #(.DATA_W(128), .LANES(2),  .SBOX_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(s2.slave), .busy(sw_busy[1]));
  aes_sbox_sub_bytes #(.DATA_W(128), .LANES(16), .SBOX_LAT(2)) dut3 (.clk(clk), .rst(rst), .bus(s3.slave), .busy(sw_busy[2]));
  aes_sbox_sub_bytes #(.DATA_W(32),  .LANES(4),  .SBOX_LAT(2)) dut4 (.clk(clk), .rst(rst), .bus(s4.slave), .busy(sw_busy[3]));

  logic         sw_valid, sw_inv;
  logic [127:0] sw_data;
  logic [3:0]   sw_ready, sw_ov;
  logic [127:0] sw_od [4];

  assign s1.in_valid = sw_valid;  assign s1.in_data = sw_data;        assign s1.in_inv = sw_inv;  assign s1.out_ready = 1'b1;
  assign s2.in_valid = sw_valid;  assign s2.in_data = sw_data;        assign s2.in_inv = sw_inv;  assign s2.out_ready = 1'b1;
  assign s3.in_valid = sw_valid;  assign s3.in_data = sw_data;        assign s3.in_inv = sw_inv;  assign s3.out_ready = 1'b1;
  assign s4.in_valid = sw_valid;  assign s4.in_data = sw_data[31:0];  assign s4.in_inv = sw_inv;  assign s4.out_ready = 1'b1;
  assign sw_ready = {s4.in_ready, s3.in_ready, s2.in_ready, s1.in_ready};
  assign sw_ov    = {s4.out_valid, s3.out_valid, s2.out_valid, s1.out_valid};
  assign sw_od[0] = s1.out_data;
  assign sw_od[1] = s2.out_data;
  assign sw_od[2] = s3.out_data;
  assign sw_od[3] = {96'b0, s4.out_data};

  // Reference model: S-box derived from GF(2^8) inversion plus the AES affine map.
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, p;
    x = a; y = b; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_model();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] binv, s;
      binv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) binv = 8'(c);
      s = binv ^ rotl8(binv, 1) ^ rotl8(binv, 2) ^ rotl8(binv, 3) ^ rotl8(binv, 4) ^ 8'h63;
      fwd_tab[b] = s;
      inv_tab[s] = 8'(b);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] w, input logic inv, input int nbytes);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nbytes; i++)
      r[8*i +: 8] = inv ? inv_tab[w[8*i +: 8]] : fwd_tab[w[8*i +: 8]];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [127:0] d, input logic inv);
    int n;
    n = 0;
    b0.in_data  = d;
    b0.in_inv   = inv;
    b0.in_valid = 1'b1;
    while (b0.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (b0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got %b expected 1", b0.in_ready);
    end
    step();
    b0.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (b0.out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    if (b0.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic run_word(input logic [127:0] d, input logic inv, output logic [127:0] res, output int lat);
    send_word(d, inv);
    wait_out(lat);
    res = b0.out_data;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.in_valid = 1'b1;
    b0.in_data  = {$urandom, $urandom, $urandom, $urandom};
    b0.in_inv   = 1'b0;
    b0.out_ready = 1'b1;
    sw_valid = 1'b0; sw_inv = 1'b0; sw_data = '0;
    repeat (3) step();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", b0.out_valid); end
    checks++; if (b0.out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", b0.out_data); end
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", b0.in_ready); end
    checks++; if (sw_busy !== 4'h0 || sw_ready !== 4'hf) begin errors++; $display("FAIL reset_sweep: busy %b ready %b expected 0000 1111", sw_busy, sw_ready); end
    b0.in_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy got %b expected 0", busy0); end
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int lat;
    run_word(128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b0, res, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL fips_latency: got %0d expected 5", lat); end
    checks++; if (res !== 128'h3052411ee55db4b8f198bfe0ae1127d4) begin errors++; $display("FAIL fips_data: got %h expected 3052411ee55db4b8f198bfe0ae1127d4", res); end
    checks++; if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin errors++; $display("FAIL fips_return_idle: in_ready %b out_valid %b expected 1 0", b0.in_ready, b0.out_valid); end
  endtask

  task automatic test_inverse();
    logic [127:0] res, back, w;
    int lat;
    run_word(128'h3052411ee55db4b8f198bfe0ae1127d4, 1'b1, res, lat);
    checks++; if (res !== 128'h0848f8e92a8dc69a2be2f4a0bee33d19) begin errors++; $display("FAIL inv_fips_data: got %h expected 0848f8e92a8dc69a2be2f4a0bee33d19", res); end
    run_word({96'h0, 32'hff530100}, 1'b0, res, lat);
    checks++; if (res !== 128'h636363636363636363636363_16ed7c63) begin errors++; $display("FAIL known_bytes_fwd: got %h expected 63..6316ed7c63", res); end
    run_word(res, 1'b1, back, lat);
    checks++; if (back !== {96'h0, 32'hff530100}) begin errors++; $display("FAIL known_bytes_inv: got %h expected 00..00ff530100", back); end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(16*k + i);
      run_word(w, 1'b0, res, lat);
      checks++; if (res !== ref_sub(w, 1'b0, 16)) begin errors++; $display("FAIL walk_fwd[%0d]: got %h expected %h", k, res, ref_sub(w, 1'b0, 16)); end
      run_word(res, 1'b1, back, lat);
      checks++; if (back !== w) begin errors++; $display("FAIL walk_inv[%0d]: got %h expected %h", k, back, w); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, held, res;
    int lat;
    bit stable;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    b0.out_ready = 1'b0;
    send_word(a, 1'b0);
    wait_out(lat);
    held = b0.out_data;
    checks++; if (held !== ref_sub(a, 1'b0, 16)) begin errors++; $display("FAIL bp_first_data: got %h expected %h", held, ref_sub(a, 1'b0, 16)); end
    b0.in_data = b; b0.in_inv = 1'b1; b0.in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (b0.out_valid !== 1'b1 || b0.out_data !== held || b0.in_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold: out_valid %b in_ready %b out_data %h expected 1 0 %h", b0.out_valid, b0.in_ready, b0.out_data, held); end
    b0.out_ready = 1'b1;
    step();
    checks++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake: out_valid %b in_ready %b expected 0 1", b0.out_valid, b0.in_ready); end
    step();
    b0.in_valid = 1'b0;
    checks++; if (busy0 !== 1'b1 || b0.in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: busy %b in_ready %b expected 1 0", busy0, b0.in_ready); end
    wait_out(lat);
    res = b0.out_data;
    checks++; if (lat != 5) begin errors++; $display("FAIL bp_second_latency: got %0d expected 5", lat); end
    checks++; if (res !== ref_sub(b, 1'b1, 16)) begin errors++; $display("FAIL bp_second_data: got %h expected %h", res, ref_sub(b, 1'b1, 16)); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [127:0] w, res;
    int lat;
    bit stale;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 1'b0);
    step();
    step();
    #1 rst = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0 || b0.out_valid !== 1'b0 || b0.out_data !== 128'h0) begin errors++; $display("FAIL mid_reset_async: busy %b out_valid %b out_data %h expected 0 0 0", busy0, b0.out_valid, b0.out_data); end
    step();
    rst = 1'b0;
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (b0.out_valid !== 1'b0 || busy0 !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale) begin errors++; $display("FAIL mid_reset_stale: out_valid %b busy %b expected 0 0", b0.out_valid, busy0); end
    w = {$urandom, $urandom, $urandom, $urandom};
    run_word(w, 1'b1, res, lat);
    checks++; if (lat != 5 || res !== ref_sub(w, 1'b1, 16)) begin errors++; $display("FAIL mid_reset_recover: lat %0d data %h expected 5 %h", lat, res, ref_sub(w, 1'b1, 16)); end
  endtask

  task automatic test_toggle();
    logic [127:0] w;
    logic inv;
    int lat;
    for (int n = 0; n < 10; n++) begin
      w   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      send_word(w, inv);
      lat = 0;
      while (b0.out_valid !== 1'b1 && lat < 40) begin
        b0.in_data = {$urandom, $urandom, $urandom, $urandom};
        b0.in_inv  = ~b0.in_inv;
        step();
        lat++;
      end
      checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== ref_sub(w, inv, 16)) begin errors++; $display("FAIL toggle_latched[%0d]: got %h expected %h", n, b0.out_data, ref_sub(w, inv, 16)); end
      step();
    end
  endtask

  task automatic test_sweep();
    int exp_lat [4];
    int nbytes [4];
    exp_lat = '{18, 10, 3, 3};
    nbytes  = '{16, 16, 16, 4};
    for (int n = 0; n < 200; n++) begin
      logic [127:0] w;
      logic inv;
      int lat [4];
      logic [127:0] got [4];
      w   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      checks++; if (sw_ready !== 4'hf) begin errors++; $display("FAIL sweep_idle[%0d]: in_ready got %b expected 1111", n, sw_ready); end
      sw_data = w; sw_inv = inv; sw_valid = 1'b1;
      step();
      sw_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin lat[k] = -1; got[k] = '0; end
      for (int c = 1; c <= 19; c++) begin
        step();
        for (int k = 0; k < 4; k++)
          if (lat[k] < 0 && sw_ov[k] === 1'b1) begin lat[k] = c; got[k] = sw_od[k]; end
      end
      for (int k = 0; k < 4; k++) begin
        checks++; if (lat[k] != exp_lat[k]) begin errors++; $display("FAIL sweep_latency[%0d] word %0d: got %0d expected %0d", k, n, lat[k], exp_lat[k]); end
        checks++; if (got[k] !== ref_sub(w, inv, nbytes[k])) begin errors++; $display("FAIL sweep_data[%0d] word %0d: got %h expected %h", k, n, got[k], ref_sub(w, inv, nbytes[k])); end
      end
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_fips();
    test_inverse();
    test_backpressure();
    test_reset_mid();
    test_toggle();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
